// File: rtl/mult_add_pkg.sv
// Shared types and sizing helpers for the iterative signed multiply-add unit.
package mult_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_add_state_t;

  localparam int MULT_ADD_DEFAULT_WIDTH = 32;

  // Counter must hold values up to WIDTH-1 with headroom for the terminal compare.
  function automatic int mult_add_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int MULT_ADD_CNT_W = mult_add_cnt_w(MULT_ADD_DEFAULT_WIDTH);

endpackage

// File: rtl/mult_add_core.sv
// Finalize step: applies the product sign, adds the addend, flags overflow.
// MULT_ADD_SATURATE_EN clamps the result on overflow instead of wrapping.
module mult_add_core
  import mult_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               sign_i,
  input  logic [WIDTH-1:0]   addend_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               error_o
);

  logic [2*WIDTH:0] mag_ext;
  logic [2*WIDTH:0] signed_acc;
  logic [2*WIDTH:0] addend_ext;
  logic [2*WIDTH:0] full;
  logic             ovf;

  always_comb begin
    mag_ext    = {1'b0, acc_i};
    signed_acc = sign_i ? -mag_ext : mag_ext;
    addend_ext = {{(WIDTH+1){addend_i[WIDTH-1]}}, addend_i};
    full       = signed_acc + addend_ext;
    // Representable only if every bit above the result sign matches it.
    ovf        = !((&full[2*WIDTH:WIDTH-1]) || !(|full[2*WIDTH:WIDTH-1]));
  end

`ifdef MULT_ADD_SATURATE_EN
  always_comb begin
    result_o = full[WIDTH-1:0];
    if (ovf) begin
      result_o = full[2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign result_o = full[WIDTH-1:0];
`endif

  assign error_o = ovf;

endmodule

// File: rtl/mult_add.sv
// Iterative signed multiply-add (A*B+C), one multiplier bit per cycle.
// Optional MULT_ADD_SATURATE_EN (see mult_add_core) clamps on overflow.
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | shift-add iterations, WIDTH cycles
// DONE  | result registered, one cycle; may accept the next request
module mult_add
  import mult_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  input  logic [WIDTH-1:0] addend_in,
  input  logic             data_valid_in,
  output logic [WIDTH-1:0] product_out,
  output logic             data_valid_out,
  output logic             error_out,
  output logic             busy_out
);

  localparam int CNT_W = mult_add_cnt_w(WIDTH);

  mult_add_state_t    state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   addend_q;
  logic               sign_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   product_q;
  logic               valid_q;
  logic               error_q;
  logic               busy_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   core_result;
  logic               core_error;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign mag_a = multiplicand_in[WIDTH-1] ? -multiplicand_in : multiplicand_in;
  assign mag_b = multiplier_in[WIDTH-1]   ? -multiplier_in   : multiplier_in;

  // mcand_q is pre-shifted each iteration, equivalent to |A| << iteration count.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  mult_add_core #(.WIDTH(WIDTH)) u_core (
    .acc_i    (acc_d),
    .sign_i   (sign_q),
    .addend_i (addend_q),
    .result_o (core_result),
    .error_o  (core_error)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      addend_q  <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (data_valid_in) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            addend_q <= addend_in;
            sign_q   <= multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            product_q <= core_result;
            error_q   <= core_error;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign product_out    = product_q;
  assign data_valid_out = valid_q;
  assign error_out      = error_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_mult_add.sv
// Directed-vector bench for mult_add (WIDTH=32), honours MULT_ADD_SATURATE_EN.
module tb_mult_add;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] c_in = '0;
  logic        dv_in = 1'b0;
  logic [31:0] product_out;
  logic        data_valid_out;
  logic        error_out;
  logic        busy_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_add #(.WIDTH(32)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .multiplicand_in (a_in),
    .multiplier_in   (b_in),
    .addend_in       (c_in),
    .data_valid_in   (dv_in),
    .product_out     (product_out),
    .data_valid_out  (data_valid_out),
    .error_out       (error_out),
    .busy_out        (busy_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, then check latency, busy profile, result and hold.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] exp_p, input logic exp_e);
    int cycles;
    bit busy_ok;
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; dv_in = 1'b1;
    cycles  = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      dv_in = 1'b0;
      cycles++;
      if (!data_valid_out && busy_out !== 1'b1) busy_ok = 1'b0;
    end while (!data_valid_out && cycles < 100);
    chk({tag, "_lat"},  64'(cycles), 64'd33);
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_p"},    64'(product_out), 64'(exp_p));
    chk({tag, "_e"},    64'(error_out), 64'(exp_e));
    chk({tag, "_bdn"},  64'(busy_out), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(data_valid_out), 64'd0);
    chk({tag, "_hold"},  64'(product_out), 64'(exp_p));
  endtask

  initial begin : main
    int pulses;
    int first_at;
    int last_at;
    bit spacing_ok;
    bit prod_ok;
    logic [31:0] sat_pos;
    logic [31:0] ovf1, ovf2, ovf3, ovf4;

    sat_pos = 32'h7FFF_FFFF;
`ifdef MULT_ADD_SATURATE_EN
    ovf1 = sat_pos;        // 0x7FFFFFFF*2
    ovf2 = sat_pos;        // -2^31 * -1
    ovf3 = 32'h8000_0000;  // -2^31 * 2
    ovf4 = sat_pos;        // 0x7FFFFFFF + 1
`else
    ovf1 = 32'hFFFF_FFFE;
    ovf2 = 32'h8000_0000;
    ovf3 = 32'h0000_0000;
    ovf4 = 32'h8000_0000;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p",    64'(product_out), 64'd0);
    chk("rst_dv",   64'(data_valid_out), 64'd0);
    chk("rst_e",    64'(error_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    rst = 1'b0;

    run_op("neg19",  32'd7,   32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFED, 1'b0);
    run_op("rt100",  32'd14,  32'd7,         32'd2,         32'd100,       1'b0);
    run_op("rtm100", 32'hFFFF_FFF2, 32'd7,   32'hFFFF_FFFE, 32'hFFFF_FF9C, 1'b0);
    run_op("zero",   32'd0,   32'd123,       32'd5,         32'd5,         1'b0);
    run_op("minx1",  32'h8000_0000, 32'd1,   32'd0,         32'h8000_0000, 1'b0);
    run_op("edge",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0);
    run_op("ovfpos", 32'h7FFF_FFFF, 32'd2,   32'd0,         ovf1,          1'b1);
    run_op("ovfmin", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,   ovf2,          1'b1);
    run_op("ovfneg", 32'h8000_0000, 32'd2,   32'd0,         ovf3,          1'b1);
    run_op("ovfadd", 32'h7FFF_FFFF, 32'd1,   32'd1,         ovf4,          1'b1);

    // Continuous requests: accepts only at IDLE/DONE edges, one pulse per 33 cycles.
    @(negedge clk);
    a_in = 32'd3; b_in = 32'd5; c_in = 32'd1; dv_in = 1'b1;
    pulses = 0; first_at = 0; last_at = 0; spacing_ok = 1'b1; prod_ok = 1'b1;
    for (int s = 1; s <= 105; s++) begin
      @(negedge clk);
      if (data_valid_out) begin
        pulses++;
        if (first_at == 0) first_at = s;
        else if (s - last_at != 33) spacing_ok = 1'b0;
        last_at = s;
        if (product_out !== 32'd16 || busy_out !== 1'b0) prod_ok = 1'b0;
      end
    end
    dv_in = 1'b0;
    chk("b2b_count", 64'(pulses), 64'd3);
    chk("b2b_first", 64'(first_at), 64'd33);
    chk("b2b_space", 64'(spacing_ok), 64'd1);
    chk("b2b_prod",  64'(prod_ok), 64'd1);
    repeat (40) @(negedge clk);
    chk("b2b_idle",  64'(busy_out), 64'd0);

    // Leave error_out set so the reset clearing it is observable.
    run_op("preab", 32'h7FFF_FFFF, 32'd2, 32'd0, ovf1, 1'b1);

    // Abort mid-RUN; a request coincident with reset must be dropped.
    @(negedge clk);
    a_in = 32'd5; b_in = 32'd6; c_in = 32'd7; dv_in = 1'b1;
    @(negedge clk);
    dv_in = 1'b0;
    repeat (9) @(negedge clk);
    chk("ab_busy_pre", 64'(busy_out), 64'd1);
    rst = 1'b1; dv_in = 1'b1;
    @(negedge clk);
    chk("ab_p",    64'(product_out), 64'd0);
    chk("ab_dv",   64'(data_valid_out), 64'd0);
    chk("ab_e",    64'(error_out), 64'd0);
    chk("ab_busy", 64'(busy_out), 64'd0);
    rst = 1'b0; dv_in = 1'b0;
    pulses = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (data_valid_out || busy_out) pulses++;
    end
    chk("ab_quiet", 64'(pulses), 64'd0);
    run_op("post", 32'd5, 32'd6, 32'd7, 32'd37, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_add.md
# mult_add

Iterative signed multiply-add unit computing `multiplicand * multiplier + addend`. It is the reconstruction side of the pipelined divider: it rebuilds `dividend = quotient * divisor + remainder`. It sits beside the divider in the fluid-physics arithmetic path and serves the force/velocity update stages, which issue one operation at a time and wait on `busy_out`. The core is a shift-add engine that retires one multiplier bit per cycle, so area is small and latency is fixed.

## Interface
- `WIDTH`, default 32: operand and result width; all operands are two's-complement signed.
- `clk_in`  in  1  sole clock, rising edge.
- `rst_in`  in  1  reset; synchronous, active-high.
- `multiplicand_in`  in  WIDTH  signed operand A.
- `multiplier_in`  in  WIDTH  signed operand B.
- `addend_in`  in  WIDTH  signed operand C.
- `data_valid_in`  in  1  request strobe. It is sampled only while the unit is not busy.
- `product_out`  out  WIDTH  result A*B+C, truncated to WIDTH bits (or saturated, see Configuration).
- `data_valid_out`  out  1  one-cycle pulse when a result is present.
- `error_out`  out  1  the exact result is not representable in signed WIDTH. Valid with `data_valid_out`.
- `busy_out`  out  1  an operation is in flight; inputs are ignored.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Accept condition: `data_valid_in` is high at a rising edge while in IDLE or DONE. On accept the unit:
  - latches |A|, |B|, C, and sign = A[WIDTH-1] ^ B[WIDTH-1];
  - clears the 2*WIDTH accumulator and the iteration counter;
  - moves to RUN.
- Magnitudes are taken as WIDTH-bit unsigned values, so negating -2^(WIDTH-1) gives 2^(WIDTH-1) and is treated as correct.
- RUN performs one iteration per edge, WIDTH iterations in total:
  - if the current LSB of the B shift register is 1, add |A| shifted left by the iteration count into the accumulator;
  - shift B right by one.
- After the final iteration the unit moves to DONE and registers the outputs:
  - full = (sign ? -acc : acc) + sign-extended C, evaluated in 2*WIDTH+1 bits;
  - `product_out` = full[WIDTH-1:0];
  - `error_out` = 1 when full lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- DONE lasts exactly one cycle. If there is no accept at that edge, the unit returns to IDLE.
- Outputs `product_out` and `error_out` hold their values until the next result is produced.
- While in RUN, `data_valid_in` is ignored; the request is not queued.

## Timing
- Reset values: `product_out`=0, `data_valid_out`=0, `error_out`=0, `busy_out`=0, state IDLE.
- Let edge N be the accepting edge.
  - `busy_out` is high from cycle N+1 through cycle N+WIDTH, and low in the DONE cycle.
  - `data_valid_out` is high only in cycle N+WIDTH+1.
  - Latency is WIDTH+1 cycles; for WIDTH=32 that is 33 cycles.
- Back-to-back operation: an accept at the DONE edge starts the next operation immediately. Throughput is one result per WIDTH+1 cycles.
- Reset asserted mid-RUN: the operation is aborted, there is no `data_valid_out` pulse, and all outputs return to their reset values on the next edge.
- Reset and `data_valid_in` high at the same edge: reset wins and the request is dropped.
- A zero operand still takes the full latency; there is no early termination.

## Configuration
- `MULT_ADD_SATURATE_EN` defined: on overflow, `product_out` is clamped to 2^(WIDTH-1)-1 for positive overflow or -2^(WIDTH-1) for negative overflow. `error_out` is still asserted.
- Not defined: `product_out` is the wrapped low WIDTH bits; `error_out` is asserted.

## Structure
- Package `mult_add_pkg` contains:
  - the state enum `mult_add_state_t` {IDLE, RUN, DONE};
  - the iteration-counter width constant, $clog2(WIDTH)+1.
- Sub-module `mult_add_core` holds the combinational finalize step: sign application, addend add, overflow detect, and saturate mux.
- The top level holds the FSM, the operand and shift registers, the accumulator, and the counter.

## Test plan
- A=7, B=-3, C=2, WIDTH=32. Expect `product_out`=-19 (0xFFFFFFED), `error_out`=0, and `data_valid_out` exactly 33 cycles after accept.
- Divider round-trip: A=14, B=7, C=2. Expect 100. Then A=-14, B=7, C=-2; expect -100.
- A=0x7FFFFFFF, B=2, C=0. Expect `error_out`=1; `product_out` is 0xFFFFFFFE without the macro and 0x7FFFFFFF with it.
- A=0x80000000, B=-1, C=0. Expect `error_out`=1; `product_out` is 0x80000000 without the macro and 0x7FFFFFFF with it.
- Drive `data_valid_in` high continuously:
  - second accept occurs at the DONE edge;
  - requests issued while busy are ignored;
  - exactly one `data_valid_out` pulse per 33 cycles.
- Assert `rst_in` at cycle 10 of RUN. Expect no `data_valid_out`, all outputs 0, `busy_out`=0. A new request after reset then completes correctly.
